// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the round-robin system bus arbiter.
package bus_arbiter_pkg;

  // Arbiter state encoding.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    BUSY    = 2'd2,
    ABORT   = 2'd3
  } state_t;

  // Default watchdog limits in clock cycles.
  localparam int DEF_GRANT_TIMEOUT       = 16;
  localparam int DEF_TRANSACTION_TIMEOUT = 1024;

endpackage

// File: rtl/bus_arbiter_rr_priority_select.sv
// Round-robin selector: rotates the request vector so the master after
// last_granted sits at bit 0, picks the lowest set bit, rotates the index back.
module rr_priority_select #(
  parameter int NR_MASTERS = 4
) (
  input  logic [NR_MASTERS-1:0]         request,
  input  logic [$clog2(NR_MASTERS)-1:0] last_granted,
  output logic [$clog2(NR_MASTERS)-1:0] selected,
  output logic                          any_request
);

  localparam int IDX_W = $clog2(NR_MASTERS);

  logic [NR_MASTERS-1:0] rotated;
  int                    start;
  int                    pick;

  // Rotate, priority-encode, rotate back.
  always_comb begin
    start   = (int'(last_granted) + 1) % NR_MASTERS;
    rotated = '0;
    pick    = 0;
    for (int i = 0; i < NR_MASTERS; i++) begin
      rotated[i] = request[(i + start) % NR_MASTERS];
    end
    for (int i = NR_MASTERS - 1; i >= 0; i--) begin
      if (rotated[i]) pick = i;
    end
    selected    = IDX_W'((pick + start) % NR_MASTERS);
    any_request = |request;
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin owner of the shared system bus. One grant at a time, tracks the
// transaction from begin to end, and reclaims the bus with two watchdogs.
module bus_arbiter_rr
  import bus_arbiter_pkg::*;
#(
  parameter int NR_MASTERS          = 4,
  parameter int GRANT_TIMEOUT       = DEF_GRANT_TIMEOUT,
  parameter int TRANSACTION_TIMEOUT = DEF_TRANSACTION_TIMEOUT
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NR_MASTERS-1:0]         request_in,
  input  logic                          begin_transaction_in,
  input  logic                          end_transaction_in,
  output logic [NR_MASTERS-1:0]         grant_out,
  output logic                          end_transaction_out,
  output logic                          bus_error_out,
  output logic [$clog2(NR_MASTERS)-1:0] active_master_out,
  output logic                          bus_busy_out
);

  localparam int IDX_W  = $clog2(NR_MASTERS);
  localparam int WAIT_W = $clog2(GRANT_TIMEOUT);
  localparam int XFER_W = $clog2(TRANSACTION_TIMEOUT);

  state_t                state_q, state_d;
  logic [NR_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [IDX_W-1:0]      active_q, active_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [XFER_W-1:0]     xfer_q, xfer_d;
  logic [IDX_W-1:0]      sel;
  logic                  any_req;

  rr_priority_select #(.NR_MASTERS(NR_MASTERS)) u_select (
    .request      (request_in),
    .last_granted (last_q),
    .selected     (sel),
    .any_request  (any_req)
  );

  // State, grant and watchdog registers; last_granted resets to the top
  // index so master 0 wins the first arbitration.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= IDX_W'(NR_MASTERS - 1);
      active_q <= '0;
      wait_q   <= '0;
      xfer_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      active_q <= active_d;
      wait_q   <= wait_d;
      xfer_q   <= xfer_d;
    end
  end

  // Next-state logic; counters only advance while staying in their state.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    active_d = active_q;
    wait_d   = wait_q;
    xfer_d   = xfer_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d  = GRANTED;
          grant_d  = {{(NR_MASTERS-1){1'b0}}, 1'b1} << sel;
          last_d   = sel;
          active_d = sel;
          wait_d   = '0;
        end
      end
      GRANTED: begin
        if (begin_transaction_in) begin
          grant_d = '0;
          if (end_transaction_in) begin
            state_d = IDLE;
          end else begin
            state_d = BUSY;
            xfer_d  = '0;
          end
        end else if (wait_q == WAIT_W'(GRANT_TIMEOUT - 1)) begin
          // Forfeit: last_granted already points at this master.
          state_d = IDLE;
          grant_d = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      BUSY: begin
        grant_d = '0;
        if (end_transaction_in) begin
          state_d = IDLE;
        end else if (xfer_q == XFER_W'(TRANSACTION_TIMEOUT - 1)) begin
          state_d = ABORT;
        end else begin
          xfer_d = xfer_q + XFER_W'(1);
        end
      end
      ABORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign grant_out           = grant_q;
  assign active_master_out   = active_q;
  assign bus_busy_out        = (state_q != IDLE);
  assign end_transaction_out = (state_q == ABORT);
  assign bus_error_out       = (state_q == ABORT);

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: the stimulus pushes the expected grant
// and abort events into a scoreboard, a negedge monitor pops and compares.
module tb_bus_arbiter_rr;

  localparam int N = 4;
  localparam logic [1:0] EV_GRANT = 2'd0;
  localparam logic [1:0] EV_ABORT = 2'd1;

  typedef struct {
    logic [1:0]   kind;
    logic [N-1:0] val;
  } ev_t;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] request_in = '0;
  logic         begin_tr = 1'b0;
  logic         end_tr = 1'b0;
  logic [N-1:0] grant_out;
  logic         end_transaction_out;
  logic         bus_error_out;
  logic [1:0]   active_master_out;
  logic         bus_busy_out;

  int n_checks = 0;
  int n_pass   = 0;
  ev_t sb[$];
  ev_t e;
  logic [N-1:0] prev_grant = '0;
  logic         prev_err   = 1'b0;

  bus_arbiter_rr #(
    .NR_MASTERS(N), .GRANT_TIMEOUT(16), .TRANSACTION_TIMEOUT(1024)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .request_in           (request_in),
    .begin_transaction_in (begin_tr),
    .end_transaction_in   (end_tr),
    .grant_out            (grant_out),
    .end_transaction_out  (end_transaction_out),
    .bus_error_out        (bus_error_out),
    .active_master_out    (active_master_out),
    .bus_busy_out         (bus_busy_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [1:0] kind, input logic [N-1:0] val);
    ev_t x;
    x.kind = kind;
    x.val  = val;
    sb.push_back(x);
  endtask

  // Called while GRANTED: begin, stay BUSY for len cycles, end in the last.
  task automatic run_xfer(input int len);
    begin_tr = 1'b1;
    tick();
    begin_tr = 1'b0;
    chk("xfer_busy", {31'd0, bus_busy_out}, 32'd1);
    chk("xfer_grant_cleared", {28'd0, grant_out}, 32'd0);
    repeat (len - 1) tick();
    end_tr = 1'b1;
    tick();
    end_tr = 1'b0;
    chk("idle_after_end", {31'd0, bus_busy_out}, 32'd0);
  endtask

  // Monitor: every new grant or abort pulse is matched against the scoreboard.
  always @(negedge clock) begin
    if (reset) begin
      if (grant_out != '0 && prev_grant == '0) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_grant", {28'd0, grant_out}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_kind_grant", {30'd0, EV_GRANT}, {30'd0, e.kind});
          chk("sb_grant", {28'd0, grant_out}, {28'd0, e.val});
          chk("sb_onehot", {31'd0, $onehot(grant_out)}, 32'd1);
        end
      end
      if (bus_error_out && !prev_err) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_abort", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_kind_abort", {30'd0, EV_ABORT}, {30'd0, e.kind});
          chk("sb_abort_end_out", {31'd0, end_transaction_out}, 32'd1);
        end
      end
    end
    prev_grant = reset ? grant_out : '0;
    prev_err   = reset ? bus_error_out : 1'b0;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic err_seen;
    // Reset state and first arbitration (master 0 first, then master 2).
    request_in = 4'b0101;
    repeat (3) tick();
    chk("rst_grant", {28'd0, grant_out}, 32'd0);
    chk("rst_busy", {31'd0, bus_busy_out}, 32'd0);
    chk("rst_err", {31'd0, bus_error_out}, 32'd0);
    chk("rst_end_out", {31'd0, end_transaction_out}, 32'd0);
    chk("rst_active", {30'd0, active_master_out}, 32'd0);
    reset = 1'b1;
    push(EV_GRANT, 4'b0001);
    tick();
    chk("first_grant", {28'd0, grant_out}, 32'h1);
    chk("first_active", {30'd0, active_master_out}, 32'd0);
    chk("first_busy", {31'd0, bus_busy_out}, 32'd1);
    request_in = 4'b0100;
    run_xfer(1);
    push(EV_GRANT, 4'b0100);
    tick();
    chk("second_grant", {28'd0, grant_out}, 32'h4);
    chk("second_active", {30'd0, active_master_out}, 32'd2);

    // Zero-length transaction: begin and end together while GRANTED.
    request_in = '0;
    begin_tr = 1'b1;
    end_tr   = 1'b1;
    tick();
    begin_tr = 1'b0;
    end_tr   = 1'b0;
    chk("zero_len_idle", {31'd0, bus_busy_out}, 32'd0);
    chk("zero_len_no_err", {31'd0, bus_error_out}, 32'd0);
    chk("zero_len_grant", {28'd0, grant_out}, 32'd0);

    // Master 1 short transaction so master 2 is next in line.
    request_in = 4'b0010;
    push(EV_GRANT, 4'b0010);
    tick();
    chk("m1_grant", {28'd0, grant_out}, 32'h2);
    request_in = '0;
    run_xfer(1);

    // Grant watchdog: master 2 never begins, master 3 wins next.
    request_in = 4'b1100;
    push(EV_GRANT, 4'b0100);
    tick();
    chk("gto_grant", {28'd0, grant_out}, 32'h4);
    cnt = 1;
    err_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus_error_out) err_seen = 1'b1;
      if (grant_out == '0) break;
      cnt++;
    end
    chk("gto_grant_cycles", cnt, 32'd16);
    chk("gto_no_error", {31'd0, err_seen}, 32'd0);
    chk("gto_idle", {31'd0, bus_busy_out}, 32'd0);
    push(EV_GRANT, 4'b1000);
    tick();
    chk("gto_next_grant", {28'd0, grant_out}, 32'h8);
    request_in = '0;
    run_xfer(2);

    // Transaction watchdog: master 1 begins and never ends.
    request_in = 4'b0010;
    push(EV_GRANT, 4'b0010);
    tick();
    chk("tto_grant", {28'd0, grant_out}, 32'h2);
    request_in = '0;
    push(EV_ABORT, '0);
    begin_tr = 1'b1;
    tick();
    begin_tr = 1'b0;
    cnt = 1;
    for (int i = 0; i < 1100; i++) begin
      tick();
      if (bus_error_out) break;
      cnt++;
    end
    chk("tto_busy_cycles", cnt, 32'd1024);
    chk("tto_end_out", {31'd0, end_transaction_out}, 32'd1);
    chk("tto_busy_in_abort", {31'd0, bus_busy_out}, 32'd1);
    tick();
    chk("tto_err_pulse_len", {31'd0, bus_error_out}, 32'd0);
    chk("tto_end_pulse_len", {31'd0, end_transaction_out}, 32'd0);
    chk("tto_idle", {31'd0, bus_busy_out}, 32'd0);

    // Reset in the middle of a BUSY transaction by master 3.
    request_in = 4'b1000;
    push(EV_GRANT, 4'b1000);
    tick();
    chk("mid_grant", {28'd0, grant_out}, 32'h8);
    request_in = '0;
    begin_tr = 1'b1;
    tick();
    begin_tr = 1'b0;
    tick();
    chk("mid_busy", {31'd0, bus_busy_out}, 32'd1);
    reset = 1'b0;
    request_in = 4'b1111;
    tick();
    chk("mid_rst_grant", {28'd0, grant_out}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus_busy_out}, 32'd0);
    chk("mid_rst_err", {31'd0, bus_error_out}, 32'd0);
    chk("mid_rst_end_out", {31'd0, end_transaction_out}, 32'd0);
    chk("mid_rst_active", {30'd0, active_master_out}, 32'd0);
    tick();
    reset = 1'b1;

    // Fairness: all masters request continuously, 3-cycle transactions.
    for (int k = 0; k < 5; k++) begin
      logic [N-1:0] g;
      g = 4'b0001 << (k % N);
      push(EV_GRANT, g);
      tick();
      chk("rr_grant", {28'd0, grant_out}, {28'd0, g});
      chk("rr_active", {30'd0, active_master_out}, k % N);
      run_xfer(3);
    end
    request_in = '0;
    repeat (3) tick();
    chk("sb_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
Name: bus_arbiter_rr

Overview:
- Round-robin arbiter sharing the single system bus between NR_MASTERS bus masters, e.g. ramDmaCi instances, the CPU data port and the camera.
- Owns grant sequencing: issues one grant at a time and tracks the transaction from begin to end.
- Reclaims the bus through two watchdogs:
  - a master that is granted but never begins a transaction;
  - a transaction that never ends.
- Sits between the masters' request/granted pins and the shared bus control signals.

Parameters:
- NR_MASTERS, 4: number of requesters, 2..16.
- GRANT_TIMEOUT, 16: cycles a granted master has to assert begin_transaction.
- TRANSACTION_TIMEOUT, 1024: maximum cycles from begin_transaction to end_transaction before a forced abort.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- request_in  in  NR_MASTERS  per-master bus request; bit i belongs to master i.
- begin_transaction_in  in  1  shared bus begin_transaction (OR of all masters).
- end_transaction_in  in  1  shared bus end_transaction.
- grant_out  out  NR_MASTERS  one-hot grant, registered.
- end_transaction_out  out  1  forced end_transaction on watchdog abort.
- bus_error_out  out  1  one-cycle error pulse on watchdog abort; drives the bus error_in of all masters.
- active_master_out  out  $clog2(NR_MASTERS)  index of the current owner; valid while bus_busy_out=1.
- bus_busy_out  out  1  1 whenever state != IDLE.

Behaviour:
- Only clock exists. reset is synchronous, active-low, and has priority over every other event.
- Values on reset (reset=0):
  - state=IDLE, all outputs 0.
  - last_granted=NR_MASTERS-1, so master 0 has first priority.
  - Counters cleared.
- States (2-bit): IDLE, GRANTED, BUSY, ABORT.
- IDLE:
  - If request_in!=0, select the first set bit scanning upward from (last_granted+1) mod NR_MASTERS, wrapping around.
  - Next cycle: state=GRANTED, grant_out=onehot(sel), last_granted=sel, active_master_out=sel.
  - Latency from request to grant is 1 cycle.
- GRANTED:
  - grant_out held.
  - wait_cnt increments each cycle.
  - If begin_transaction_in=1: go to BUSY and clear grant_out.
    - If end_transaction_in=1 in the same cycle (zero-length transaction), go to IDLE instead.
  - Otherwise, if wait_cnt==GRANT_TIMEOUT-1: go to IDLE and clear grant_out. No error is raised; the master forfeits its turn because last_granted is already updated.
  - Dropping request_in while GRANTED has no effect. Masters drop request once granted.
- BUSY:
  - grant_out=0.
  - xfer_cnt increments each cycle.
  - If end_transaction_in=1: go to IDLE. This leaves a minimum of 1 IDLE cycle between transactions.
  - Otherwise, if xfer_cnt==TRANSACTION_TIMEOUT-1: go to ABORT.
- ABORT (exactly 1 cycle):
  - end_transaction_out=1 and bus_error_out=1 (both driven combinationally from state).
  - Then go to IDLE.
- Counters:
  - Widths are $clog2(timeout) bits.
  - Cleared on entry to GRANTED and BUSY respectively; they never wrap within a state.
- Fairness: with all NR_MASTERS requesting continuously, grants cycle 0,1,...,N-1,0.
- A request arriving while not in IDLE is simply held and evaluated at the next IDLE.
- Glitch-free: grant_out is one-hot or zero at all times.

Decomposition:
- Package bus_arbiter_pkg holds:
  - the state encoding localparams (IDLE=0, GRANTED=1, BUSY=2, ABORT=3);
  - default timeout constants.
- Sub-module rr_priority_select (combinational):
  - inputs: request vector, last_granted index;
  - outputs: selected index, any_request flag.
  - Implemented as a rotate, priority-encode, rotate-back.

Test Plan:
- Reset release with request_in=4'b0101 → grant_out=4'b0001 one cycle after the first non-reset edge. Master 0 begins and ends → next grant 4'b0100.
- All four masters request continuously, each completing a 3-cycle transaction → grant order 0,1,2,3,0; exactly 1 IDLE cycle between the end of one transaction and the next grant.
- Master 2 is granted and never asserts begin → grant_out drops after 16 cycles, no bus_error_out. Master 3 (requesting) is granted next, not master 2.
- Master 1 begins and never ends → after 1024 BUSY cycles, end_transaction_out and bus_error_out are high for exactly 1 cycle, then IDLE.
- begin_transaction_in and end_transaction_in in the same cycle during GRANTED → IDLE the next cycle with no ABORT.
- reset=0 asserted mid-BUSY → next cycle all outputs 0 and state=IDLE. After release, master 0 again has top priority.
